// File: rtl/mips_pkg.sv
// Shared register-file constants for the MIPS-style pipeline blocks.
package mips_pkg;
    localparam int REG_ADDR_W  = 5;
    localparam int NREGS       = 32;
    localparam int CNT_W       = 2;
    localparam int MAX_PENDING = 3;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    // Register 0 never writes back, so it is never tracked.
    function automatic logic is_tracked(input logic [REG_ADDR_W-1:0] r);
        return r != REG_ZERO;
    endfunction
endpackage

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one register, with overflow/underflow flags.
module sb_counter
    import mips_pkg::*;
#(
    parameter int MAX = MAX_PENDING
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_flush,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_busy,
    output logic o_ovf,
    output logic o_unf
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic             w_empty;
    logic             w_up;
    logic             w_dn;

    assign w_full  = (r_cnt == CNT_W'(MAX));
    assign w_empty = (r_cnt == '0);
    // A same-cycle issue and retire cancel out and are never an error.
    assign w_up    = i_inc && !i_dec;
    assign w_dn    = i_dec && !i_inc;

    assign o_ovf  = !i_flush && w_up && w_full;
    assign o_unf  = !i_flush && w_dn && w_empty;
    assign o_busy = !w_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_flush)
            r_cnt <= '0;
        else if (w_up && !w_full)
            r_cnt <= r_cnt + 1'b1;
        else if (w_dn && !w_empty)
            r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register and stalls decode on RAW hazards.
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int MAX_PENDING = mips_pkg::MAX_PENDING,
    parameter int NREGS       = mips_pkg::NREGS
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_dest,
    input  logic                  i_retire_valid,
    input  logic [REG_ADDR_W-1:0] i_retire_dest,
    input  logic                  i_flush,
    input  logic [REG_ADDR_W-1:0] i_src_a,
    input  logic [REG_ADDR_W-1:0] i_src_b,
    output logic                  o_stall,
    output logic [NREGS-1:0]      o_busy_mask,
    output logic                  o_err
);
    logic [NREGS-1:0] w_busy;
    logic [NREGS-1:0] w_ovf;
    logic [NREGS-1:0] w_unf;
    logic             w_iss;
    logic             w_ret;
    logic             r_err;

    assign w_iss = i_issue_valid  && is_tracked(i_issue_dest);
    assign w_ret = i_retire_valid && is_tracked(i_retire_dest);

    assign w_busy[0] = 1'b0;
    assign w_ovf[0]  = 1'b0;
    assign w_unf[0]  = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_reg
        sb_counter #(.MAX(MAX_PENDING)) u_cnt (
            .i_clk   (i_clock),
            .i_rst   (i_reset),
            .i_flush (i_flush),
            .i_inc   (w_iss && (i_issue_dest  == REG_ADDR_W'(g))),
            .i_dec   (w_ret && (i_retire_dest == REG_ADDR_W'(g))),
            .o_busy  (w_busy[g]),
            .o_ovf   (w_ovf[g]),
            .o_unf   (w_unf[g])
        );
    end

    // Counters are registers, so the mask reflects state right after each edge.
    assign o_busy_mask = w_busy;
    assign o_stall     = w_busy[i_src_a] | w_busy[i_src_b];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_err <= 1'b0;
        else
            r_err <= r_err | (|w_ovf) | (|w_unf);
    end

    assign o_err = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard using a reference model and expected-result queue.
module tb_reg_scoreboard;
    localparam int MAXP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, retire_valid, flush;
    logic [4:0]  issue_dest, retire_dest, src_a, src_b;
    logic        stall, err;
    logic [31:0] busy_mask;

    typedef struct packed {
        logic [31:0] busy;
        logic        err;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt[32];
    logic m_err;
    int   n_cmp = 0;
    int   n_bad = 0;

    reg_scoreboard dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_issue_valid  (issue_valid),
        .i_issue_dest   (issue_dest),
        .i_retire_valid (retire_valid),
        .i_retire_dest  (retire_dest),
        .i_flush        (flush),
        .i_src_a        (src_a),
        .i_src_b        (src_b),
        .o_stall        (stall),
        .o_busy_mask    (busy_mask),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    function automatic logic m_stall(input logic [4:0] a, input logic [4:0] b);
        logic [31:0] bm = m_busy();
        return bm[a] | bm[b];
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    endtask

    // Apply one cycle of stimulus, advance the model, then check after the edge.
    task automatic step(input logic iv, input logic [4:0] id, input logic rv, input logic [4:0] rd,
                        input logic fl, input logic [4:0] sa, input logic [4:0] sb, input string tag);
        exp_t e;
        issue_valid = iv; issue_dest = id;
        retire_valid = rv; retire_dest = rd;
        flush = fl; src_a = sa; src_b = sb;
        #1;
        chk({tag, "/stall_pre"}, {31'd0, stall}, {31'd0, m_stall(sa, sb)});
        if (fl) m_clear();
        else begin
            for (int r = 1; r < 32; r++) begin
                logic inc, dec;
                inc = iv && (id == 5'(r));
                dec = rv && (rd == 5'(r));
                if (inc && !dec) begin
                    if (m_cnt[r] == MAXP) m_err = 1'b1; else m_cnt[r]++;
                end else if (dec && !inc) begin
                    if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r]--;
                end
            end
        end
        e.busy = m_busy(); e.err = m_err; e.stall = m_stall(sa, sb);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "/queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "/busy"},  busy_mask, e.busy);
            chk({tag, "/err"},   {31'd0, err},   {31'd0, e.err});
            chk({tag, "/stall"}, {31'd0, stall}, {31'd0, e.stall});
        end
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_clear(); m_err = 1'b0;
    endtask

    initial begin
        issue_valid = 0; issue_dest = 0; retire_valid = 0; retire_dest = 0;
        flush = 0; src_a = 5'd5; src_b = 5'd31;
        m_clear(); m_err = 1'b0;
        rst = 1'b1;
        #3;
        chk("reset/busy",  busy_mask, 32'd0);
        chk("reset/err",   {31'd0, err},   32'd0);
        chk("reset/stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // dest 0 is not tracked; retire of 0 is ignored
        step(1, 0, 0, 0, 0, 0, 0, "zero_issue");
        step(0, 0, 1, 0, 0, 0, 0, "zero_retire");

        // RAW hazard on r5, released only after the retire edge
        step(1, 5, 0, 0, 0, 0, 0, "iss5");
        step(0, 0, 0, 0, 0, 5, 0, "hazard5");
        chk("hazard5/mask", busy_mask, 32'h0000_0020);
        step(0, 0, 1, 5, 0, 5, 0, "ret5");
        chk("ret5/stall_released", {31'd0, stall}, 32'd0);

        // same-cycle issue/retire on r7 with count 1
        step(1, 7, 0, 0, 0, 7, 0, "iss7");
        step(1, 7, 1, 7, 0, 0, 7, "iss_ret7");
        chk("iss_ret7/bit7", {31'd0, busy_mask[7]}, 32'd1);
        step(0, 0, 1, 7, 0, 0, 7, "ret7");

        // flush overrides a concurrent issue
        step(1, 3, 0, 0, 0, 0, 0, "iss3");
        step(1, 9, 0, 0, 0, 3, 9, "iss9");
        step(1, 4, 0, 0, 1, 3, 4, "flush");
        chk("flush/mask", busy_mask, 32'd0);

        // saturation on r31, then drain
        for (int k = 0; k < 3; k++) step(1, 31, 0, 0, 0, 31, 0, "iss31");
        step(1, 31, 0, 0, 0, 31, 0, "ovf31");
        chk("ovf31/err", {31'd0, err}, 32'd1);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 31, 0, 0, 31, "ret31");
        chk("ret31/bit31", {31'd0, busy_mask[31]}, 32'd0);
        step(1, 2, 0, 0, 1, 0, 0, "flush_keeps_err");

        // underflow on r12 then asynchronous reset between edges
        sync_reset();
        step(0, 0, 1, 12, 0, 0, 0, "unf12");
        step(1, 6, 0, 0, 0, 6, 0, "iss6");
        #2 rst = 1'b1;
        #1;
        chk("async_rst/err",   {31'd0, err},   32'd0);
        chk("async_rst/busy",  busy_mask,      32'd0);
        chk("async_rst/stall", {31'd0, stall}, 32'd0);
        m_clear(); m_err = 1'b0;
        #1 rst = 1'b0;
        step(1, 8, 0, 0, 0, 8, 0, "post_rst");

        // random traffic against the model
        for (int k = 0; k < 60; k++) begin
            logic [4:0] id, rd;
            id = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), id, 1'($urandom_range(0, 1)), rd,
                 1'($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), "rand");
        end
        idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
